// File: rtl/pin_verify_pkg.sv
// Shared state encoding, default parameter values and width helpers for pin_verify.
package pin_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        ENTRY   = 3'd1,
        CHECK   = 3'd2,
        OK      = 3'd3,
        BAD     = 3'd4,
        LOCKOUT = 3'd5
    } state_e;

    localparam int DIGIT_W_DEF        = 2;
    localparam int PIN_LEN_DEF        = 4;
    localparam int MAX_TRIES_DEF      = 3;
    localparam int HOLD_CYCLES_DEF    = 4;
    localparam int LOCKOUT_CYCLES_DEF = 16;

    function automatic int pin_w(input int digit_w, input int pin_len);
        return digit_w * pin_len;
    endfunction

    function automatic int cnt_w(input int pin_len);
        return $clog2(pin_len + 1);
    endfunction

    function automatic int try_w(input int max_tries);
        return $clog2(max_tries + 1);
    endfunction

    function automatic int tmr_w(input int hold_cycles, input int lockout_cycles);
        return $clog2(((hold_cycles > lockout_cycles) ? hold_cycles : lockout_cycles) + 1);
    endfunction

endpackage

// File: rtl/pin_verify_if.sv
// Keypad-side strobes and status outputs of the PIN checker.
interface pin_verify_if import pin_pkg::*; #(
    parameter int DIGIT_W   = DIGIT_W_DEF,
    parameter int PIN_LEN   = PIN_LEN_DEF,
    parameter int MAX_TRIES = MAX_TRIES_DEF
);
    localparam int CNT_W = cnt_w(PIN_LEN);
    localparam int TRY_W = try_w(MAX_TRIES);

    logic [DIGIT_W-1:0] digit;
    logic               submit;
    logic               clear;
    logic               waiting;
    logic               correct;
    logic               incorrect;
    logic               locked;
    logic [CNT_W-1:0]   digits_entered;
    logic [TRY_W-1:0]   tries_left;
    logic               bug;

    modport master (
        output digit, submit, clear,
        input  waiting, correct, incorrect, locked, digits_entered, tries_left, bug
    );

    modport slave (
        input  digit, submit, clear,
        output waiting, correct, incorrect, locked, digits_entered, tries_left, bug
    );
endinterface

// File: rtl/pin_verify_hold_timer.sv
// Down-counter timing the correct/incorrect hold and the lockout window.
module hold_timer #(
    parameter int W = 5
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         load_i,
    input  logic [W-1:0] load_val_i,
    output logic         busy_o,
    output logic         done_o
);
    logic [W-1:0] count_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count_q <= '0;
        end else if (load_i) begin
            count_q <= load_val_i;
        end else if (count_q != '0) begin
            count_q <= count_q - W'(1);
        end
    end

    // done marks the final cycle of the window so the owner leaves on the next edge
    assign done_o = (count_q == W'(1));
    assign busy_o = (count_q != '0);
endmodule

// File: rtl/pin_verify.sv
// PIN entry FSM: shifts in digits, compares against PASSKEY, holds result flags and locks out.
module pin_verify import pin_pkg::*; #(
    parameter int DIGIT_W                           = DIGIT_W_DEF,
    parameter int PIN_LEN                           = PIN_LEN_DEF,
    parameter logic [DIGIT_W*PIN_LEN-1:0] PASSKEY   = 8'b10100101,
    parameter int MAX_TRIES                         = MAX_TRIES_DEF,
    parameter int HOLD_CYCLES                       = HOLD_CYCLES_DEF,
    parameter int LOCKOUT_CYCLES                    = LOCKOUT_CYCLES_DEF
) (
    input  logic         clk,
    input  logic         reset_n,
    pin_verify_if.slave  bus
);
    localparam int PIN_W = pin_w(DIGIT_W, PIN_LEN);
    localparam int CNT_W = cnt_w(PIN_LEN);
    localparam int TRY_W = try_w(MAX_TRIES);
    localparam int TMR_W = tmr_w(HOLD_CYCLES, LOCKOUT_CYCLES);

    localparam logic [CNT_W-1:0] LAST_DIGIT = CNT_W'(PIN_LEN - 1);
    localparam logic [TRY_W-1:0] TRIES_MAX  = TRY_W'(MAX_TRIES);
    localparam logic [TMR_W-1:0] HOLD_LD    = TMR_W'(HOLD_CYCLES);
    localparam logic [TMR_W-1:0] LOCK_LD    = TMR_W'(LOCKOUT_CYCLES);

    state_e           state_q;
    logic [PIN_W-1:0] pin_q, pin_d;
    logic [CNT_W-1:0] cnt_q;
    logic [TRY_W-1:0] tries_q;
    logic             waiting_q, correct_q, incorrect_q, locked_q, bug_q;
    logic             match, tmr_load, tmr_busy, tmr_done;
    logic [TMR_W-1:0] tmr_val;

    generate
        if (PIN_LEN == 1) begin : g_single
            assign pin_d = bus.digit;
        end else begin : g_shift
            assign pin_d = {pin_q[PIN_W-DIGIT_W-1:0], bus.digit};
        end
    endgenerate

    assign match    = (pin_q == PASSKEY);
    assign tmr_load = (state_q == CHECK);
    assign tmr_val  = (match || tries_q != TRY_W'(1)) ? HOLD_LD : LOCK_LD;

    hold_timer #(.W(TMR_W)) u_timer (
        .clk        (clk),
        .reset_n    (reset_n),
        .load_i     (tmr_load),
        .load_val_i (tmr_val),
        .busy_o     (tmr_busy),
        .done_o     (tmr_done)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            pin_q       <= '0;
            cnt_q       <= '0;
            tries_q     <= TRIES_MAX;
            waiting_q   <= 1'b1;
            correct_q   <= 1'b0;
            incorrect_q <= 1'b0;
            locked_q    <= 1'b0;
            bug_q       <= 1'b0;
        end else begin
            case (state_q)
                IDLE, ENTRY: begin
                    // clear wins over a coincident submit
                    if (bus.clear) begin
                        pin_q   <= '0;
                        cnt_q   <= '0;
                        state_q <= IDLE;
                    end else if (bus.submit) begin
                        pin_q <= pin_d;
                        cnt_q <= cnt_q + CNT_W'(1);
                        if (cnt_q == LAST_DIGIT) begin
                            state_q   <= CHECK;
                            waiting_q <= 1'b0;
                        end else begin
                            state_q <= ENTRY;
                        end
                    end
                end
                CHECK: begin
                    cnt_q <= '0;
                    pin_q <= '0;
                    if (match) begin
                        state_q   <= OK;
                        correct_q <= 1'b1;
                        tries_q   <= TRIES_MAX;
                    end else if (tries_q > TRY_W'(1)) begin
                        state_q     <= BAD;
                        incorrect_q <= 1'b1;
                        tries_q     <= tries_q - TRY_W'(1);
                    end else begin
                        state_q     <= LOCKOUT;
                        incorrect_q <= 1'b1;
                        locked_q    <= 1'b1;
                        tries_q     <= '0;
                    end
                end
                OK, BAD: begin
                    if (tmr_done || !tmr_busy) begin
                        state_q     <= IDLE;
                        correct_q   <= 1'b0;
                        incorrect_q <= 1'b0;
                        waiting_q   <= 1'b1;
                    end
                end
                LOCKOUT: begin
                    if (tmr_done || !tmr_busy) begin
                        state_q     <= IDLE;
                        incorrect_q <= 1'b0;
                        locked_q    <= 1'b0;
                        waiting_q   <= 1'b1;
                        tries_q     <= TRIES_MAX;
                    end
                end
                default: begin
                    bug_q       <= 1'b1;
                    state_q     <= IDLE;
                    pin_q       <= '0;
                    cnt_q       <= '0;
                    waiting_q   <= 1'b1;
                    correct_q   <= 1'b0;
                    incorrect_q <= 1'b0;
                    locked_q    <= 1'b0;
                end
            endcase
        end
    end

    assign bus.waiting        = waiting_q;
    assign bus.correct        = correct_q;
    assign bus.incorrect      = incorrect_q;
    assign bus.locked         = locked_q;
    assign bus.digits_entered = cnt_q;
    assign bus.tries_left     = tries_q;
    assign bus.bug            = bug_q;
endmodule
